// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator frequency measurement controller with a per-channel byte-stream result.
// Latency: per channel, SETTLE + 2^AVG_LOG2*(WIN+1) cycles of measurement, then 1+CW/8 bytes.
// Backpressure: tx_valid/tx_ready; each byte is held stable until accepted, and the next byte follows one cycle later.
//
// Ports:
//   clk, reset        system clock and asynchronous active-high reset
//   en                block enable; dropping it aborts the sweep back to IDLE
//   start, ch_mask    sweep request and the channels to measure (latched on accept)
//   ro_in             oscillator outputs (asynchronous); osc_en is the one-hot enable of the active one
//   tx_data/valid/rdy result byte stream: channel index, then the result LSB first
//   busy, done        not-IDLE flag; one-cycle completion pulse
module ro_meas_ctrl #(
  parameter int CH       = 4,
  parameter int CW       = 16,
  parameter int WIN      = 1000,
  parameter int AVG_LOG2 = 3,
  parameter int SETTLE   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          start,
  input  logic [CH-1:0] ch_mask,
  input  logic [CH-1:0] ro_in,
  output logic [CH-1:0] osc_en,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done
);

  localparam int CIW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int TMAX = (WIN > SETTLE) ? WIN : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int AW   = CW + AVG_LOG2;
  localparam int NB   = CW / 8;
  localparam int BW   = $clog2(NB + 1);
  localparam int WCW  = AVG_LOG2 + 1;

  typedef enum logic [2:0] {
    IDLE, SETTLE_S, GATE, ACCUM, SEND, NEXT
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [WCW-1:0]  win_cnt;
  logic [CH-1:0]   mask;
  logic [CIW-1:0]  cur;
  logic [BW-1:0]   bidx;
  logic            done_q;

  // Third flop holds the previous synchronised level for rising-edge detection.
  logic [CH-1:0]   ro_s1, ro_s2, ro_s3;

  logic [CH-1:0]   cur_onehot;
  logic [CH-1:0]   mask_rem;
  logic [CW-1:0]   result;
  logic            rise;
  logic            settle_end;
  logic            gate_end;
  logic            last_win;
  logic            last_byte;

  function automatic logic [CIW-1:0] lowest(input logic [CH-1:0] m);
    lowest = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (m[i]) lowest = CIW'(i);
    end
  endfunction

  assign cur_onehot = CH'(1) << cur;
  assign mask_rem   = mask & ~cur_onehot;
  assign result     = acc[AW-1:AVG_LOG2];
  assign rise       = ro_s2[cur] & ~ro_s3[cur];
  assign settle_end = (timer == TW'(SETTLE - 1));
  assign gate_end   = (timer == TW'(WIN - 1));
  assign last_win   = (win_cnt == WCW'((1 << AVG_LOG2) - 1));
  assign last_byte  = (bidx == BW'(NB));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && en && (ch_mask != '0)) state_nxt = SETTLE_S;
      SETTLE_S: if (settle_end) state_nxt = GATE;
      GATE:     if (gate_end) state_nxt = ACCUM;
      ACCUM:    state_nxt = last_win ? SEND : GATE;
      SEND:     if (tx_ready && last_byte) state_nxt = NEXT;
      NEXT:     state_nxt = (mask_rem != '0) ? SETTLE_S : IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;
  end

  always_comb begin
    busy     = (state != IDLE);
    osc_en   = '0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    done     = done_q;
    if (state == SETTLE_S || state == GATE || state == ACCUM) osc_en = cur_onehot;
    if (state == SEND) begin
      tx_valid = 1'b1;
      if (bidx == '0) tx_data = {{(8 - CIW){1'b0}}, cur};
      for (int b = 0; b < NB; b++) begin
        if (bidx == BW'(b + 1)) tx_data = result[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ro_s1 <= '0;
      ro_s2 <= '0;
      ro_s3 <= '0;
    end else begin
      ro_s1 <= ro_in;
      ro_s2 <= ro_s1;
      ro_s3 <= ro_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      cnt     <= '0;
      acc     <= '0;
      win_cnt <= '0;
      mask    <= '0;
      cur     <= '0;
      bidx    <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start && en) begin
            if (ch_mask != '0) begin
              mask  <= ch_mask;
              cur   <= lowest(ch_mask);
              timer <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SETTLE_S: begin
          timer <= timer + 1'b1;
          if (settle_end) begin
            timer   <= '0;
            cnt     <= '0;
            acc     <= '0;
            win_cnt <= '0;
          end
        end
        GATE: begin
          // Saturate rather than wrap so an over-range oscillator reads full scale.
          if (rise && (cnt != '1)) cnt <= cnt + 1'b1;
          timer <= gate_end ? '0 : timer + 1'b1;
        end
        ACCUM: begin
          acc     <= acc + AW'(cnt);
          cnt     <= '0;
          win_cnt <= win_cnt + 1'b1;
          bidx    <= '0;
        end
        SEND: begin
          if (tx_ready) bidx <= bidx + 1'b1;
        end
        NEXT: begin
          mask  <= mask_rem;
          cur   <= lowest(mask_rem);
          timer <= '0;
          if (en && (mask_rem == '0)) done_q <= 1'b1;
        end
        default: ;
      endcase
      // Abort: discard everything belonging to the sweep in progress.
      if (!en && (state != IDLE)) begin
        timer   <= '0;
        cnt     <= '0;
        acc     <= '0;
        win_cnt <= '0;
        mask    <= '0;
        bidx    <= '0;
        done_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ro_meas_ctrl.sv
module tb_ro_meas_ctrl;

  logic       clk, reset, en;
  logic       start_a, start_b;
  logic [1:0] mask_a, mask_b;
  logic [1:0] ro_a, ro_b;
  logic [1:0] osc_en_a, osc_en_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       tx_ready, tx_ready_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic       ro0, ro1, rob;
  int         hp0, hp1, hpb;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int byte_cnt = 0;
  int done_b_cnt = 0;

  typedef struct { logic [7:0] lo; logic [7:0] hi; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] got_b[$];

  typedef struct {
    logic [1:0] mask;
    int hp0, hp1;
    int lo0, hi0, lo1, hi1;
  } vec_t;
  vec_t vt[5];

  ro_meas_ctrl #(.CH(2), .CW(16), .WIN(100), .AVG_LOG2(1), .SETTLE(4)) dut_a (
    .clk(clk), .reset(reset), .en(en), .start(start_a), .ch_mask(mask_a), .ro_in(ro_a),
    .osc_en(osc_en_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
    .busy(busy_a), .done(done_a));

  ro_meas_ctrl #(.CH(2), .CW(8), .WIN(1000), .AVG_LOG2(1), .SETTLE(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .start(start_b), .ch_mask(mask_b), .ro_in(ro_b),
    .osc_en(osc_en_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .busy(busy_b), .done(done_b));

  assign ro_a = {ro1, ro0};
  assign ro_b = {1'b0, rob};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillators deliberately offset from the clock edges.
  initial begin ro0 = 1'b0; #3; forever begin #(hp0); ro0 = ~ro0; end end
  initial begin ro1 = 1'b0; #4; forever begin #(hp1); ro1 = ~ro1; end end
  initial begin rob = 1'b0; #7; forever begin #(hpb); rob = ~rob; end end

  task automatic chk(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got %0d want %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: an accepted byte is the one seen with valid&ready just before the edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (done_a) done_cnt++;
      if (done_b) done_b_cnt++;
      if (tx_valid_b && tx_ready_b) got_b.push_back(tx_data_b);
      if (tx_valid_a && tx_ready) begin
        byte_cnt++;
        chk("osc_off_in_send", int'(osc_en_a), 0, 0);
        if (sb.size() == 0) begin
          chk("unexpected_byte", int'(tx_data_a), -1, -1);
        end else begin
          mon_e = sb.pop_front();
          chk("tx_byte", int'(tx_data_a), int'(mon_e.lo), int'(mon_e.hi));
        end
      end
    end
  end

  task automatic push_ch(input int c, input int lo, input int hi);
    sb.push_back('{8'(c), 8'(c)});
    sb.push_back('{8'(lo), 8'(hi)});
    sb.push_back('{8'h00, 8'h00});
  endtask

  task automatic run_sweep(input logic [1:0] m, input int nb, input string tag);
    int d0, b0;
    d0 = done_cnt;
    b0 = byte_cnt;
    mask_a = m;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(negedge clk);
    step(3);
    chk({tag, "_done"}, done_cnt - d0, 1, 1);
    chk({tag, "_bytes"}, byte_cnt - b0, nb, nb);
    chk({tag, "_sb_empty"}, sb.size(), 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, d0, b0;
    logic [7:0] held;

    vt[0] = '{2'b01, 40, 20, 12, 13, 0, 0};
    vt[1] = '{2'b11, 40, 20, 12, 13, 24, 26};
    vt[2] = '{2'b10, 40, 20, 0, 0, 24, 26};
    vt[3] = '{2'b00, 40, 20, 0, 0, 0, 0};
    vt[4] = '{2'b11, 60, 40, 8, 9, 12, 13};

    hp0 = 40; hp1 = 20; hpb = 20;
    reset = 1'b1; en = 1'b1; start_a = 1'b0; start_b = 1'b0;
    mask_a = 2'b00; mask_b = 2'b01; tx_ready = 1'b1; tx_ready_b = 1'b1;
    step(3);
    @(negedge clk);
    chk("rst_osc_en", int'(osc_en_a), 0, 0);
    chk("rst_tx_data", int'(tx_data_a), 0, 0);
    chk("rst_tx_valid", int'(tx_valid_a), 0, 0);
    chk("rst_busy", int'(busy_a), 0, 0);
    chk("rst_done", int'(done_a), 0, 0);
    step();
    reset = 1'b0;
    step(2);

    // Table-driven sweeps.
    for (int v = 0; v < 5; v++) begin
      hp0 = vt[v].hp0;
      hp1 = vt[v].hp1;
      step(12);
      nb = 0;
      if (vt[v].mask[0]) begin push_ch(0, vt[v].lo0, vt[v].hi0); nb += 3; end
      if (vt[v].mask[1]) begin push_ch(1, vt[v].lo1, vt[v].hi1); nb += 3; end
      run_sweep(vt[v].mask, nb, $sformatf("vec%0d", v));
    end

    // Empty mask: done exactly one cycle after the start, never busy, no bytes.
    hp0 = 40; hp1 = 20;
    mask_a = 2'b00;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("zero_done", int'(done_a), 1, 1);
    chk("zero_valid", int'(tx_valid_a), 0, 0);
    chk("zero_busy", int'(busy_a), 0, 0);
    step();
    chk("zero_done_clear", int'(done_a), 0, 0);

    // Start while busy and a mask change after acceptance are both ignored.
    push_ch(0, 12, 13);
    d0 = done_cnt; b0 = byte_cnt;
    mask_a = 2'b01;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(15);
    chk("osc_en_measure", int'(osc_en_a), 1, 1);
    mask_a = 2'b11;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(negedge clk);
    step(30);
    chk("busy_start_done", done_cnt - d0, 1, 1);
    chk("busy_start_bytes", byte_cnt - b0, 3, 3);

    // Backpressure on the second byte.
    push_ch(0, 12, 13);
    d0 = done_cnt; b0 = byte_cnt;
    tx_ready = 1'b0;
    mask_a = 2'b01;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 3000 && !tx_valid_a; k++) @(negedge clk);
    chk("bp_valid_seen", int'(tx_valid_a), 1, 1);
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    @(negedge clk);
    held = tx_data_a;
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid_held", int'(tx_valid_a), 1, 1);
      chk("bp_data_held", int'(tx_data_a), int'(held), int'(held));
      @(negedge clk);
    end
    step();
    tx_ready = 1'b1;
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(negedge clk);
    step(3);
    chk("bp_done", done_cnt - d0, 1, 1);
    chk("bp_bytes", byte_cnt - b0, 3, 3);
    chk("bp_sb_empty", sb.size(), 0, 0);

    // Abort from GATE with en low.
    d0 = done_cnt; b0 = byte_cnt;
    mask_a = 2'b01;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(20);
    chk("abort_pre_osc", int'(osc_en_a), 1, 1);
    en = 1'b0;
    step();
    en = 1'b1;
    chk("abort_busy", int'(busy_a), 0, 0);
    chk("abort_osc_en", int'(osc_en_a), 0, 0);
    chk("abort_valid", int'(tx_valid_a), 0, 0);
    step(300);
    chk("abort_no_done", done_cnt - d0, 0, 0);
    chk("abort_no_bytes", byte_cnt - b0, 0, 0);

    // Reset in the middle of the byte stream; nothing resumes afterwards.
    d0 = done_cnt; b0 = byte_cnt;
    tx_ready = 1'b0;
    mask_a = 2'b01;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 3000 && !tx_valid_a; k++) @(negedge clk);
    chk("rstmid_valid_seen", int'(tx_valid_a), 1, 1);
    step();
    reset = 1'b1;
    #1;
    chk("rstmid_valid", int'(tx_valid_a), 0, 0);
    chk("rstmid_busy", int'(busy_a), 0, 0);
    chk("rstmid_data", int'(tx_data_a), 0, 0);
    step(2);
    reset = 1'b0;
    tx_ready = 1'b1;
    step(300);
    chk("rstmid_no_done", done_cnt - d0, 0, 0);
    chk("rstmid_no_bytes", byte_cnt - b0, 0, 0);

    // Narrow counter: in range, then forced over range must read full scale.
    for (int r = 0; r < 2; r++) begin
      hpb = (r == 0) ? 20 : 15;
      step(12);
      got_b.delete();
      d0 = done_b_cnt;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int k = 0; k < 5000 && done_b_cnt == d0; k++) @(negedge clk);
      step(3);
      chk("sat_done", done_b_cnt - d0, 1, 1);
      chk("sat_nbytes", got_b.size(), 2, 2);
      if (got_b.size() == 2) begin
        chk("sat_chan", int'(got_b[0]), 0, 0);
        if (r == 0) chk("sat_in_range", int'(got_b[1]), 249, 251);
        else        chk("sat_full_scale", int'(got_b[1]), 255, 255);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
